// File: rtl/battle_controller_if.sv
// Handshake bundle between the battle turn sequencer and its neighbours
// (input debouncers, enemy phase block, HUD and render).
interface battle_controller_if;
  logic       start_in;
  logic       confirm_in;
  logic       busy_in;
  logic       finished_in;
  logic       damage_in;
  logic [3:0] state_out;
  logic [3:0] turn_out;
  logic [7:0] player_hp_out;
  logic [7:0] enemy_hp_out;
  logic       game_over_out;
  logic       hit_flash_out;

  modport master (
    output start_in, confirm_in, busy_in, finished_in, damage_in,
    input  state_out, turn_out, player_hp_out, enemy_hp_out,
           game_over_out, hit_flash_out
  );

  modport slave (
    input  start_in, confirm_in, busy_in, finished_in, damage_in,
    output state_out, turn_out, player_hp_out, enemy_hp_out,
           game_over_out, hit_flash_out
  );
endinterface

// File: rtl/battle_controller.sv
// Battle turn sequencer: menu -> player attack -> enemy phase, owning both HP
// pools, the post-hit invulnerability window, the enemy watchdog and win/lose.
module battle_controller #(
  parameter int PLAYER_HP     = 20,
  parameter int ENEMY_HP      = 30,
  parameter int HIT_DAMAGE    = 4,
  parameter int ATTACK_DAMAGE = 5,
  parameter int ATTACK_CYCLES = 32500000,
  parameter int INVULN_CYCLES = 6500000,
  parameter int ENEMY_TIMEOUT = 650000000
) (
  input  logic          clk,
  input  logic          rst,
  battle_controller_if.slave bus
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0000,
    ST_MENU   = 4'b0001,
    ST_ATTACK = 4'b0010,
    ST_WIN    = 4'b0100,
    ST_LOSE   = 4'b0101,
    ST_ENEMY  = 4'b1000
  } state_t;

  localparam logic [31:0] ATTACK_LAST    = 32'(ATTACK_CYCLES - 1);
  localparam logic [31:0] ENEMY_LAST     = 32'(ENEMY_TIMEOUT - 1);
  localparam logic [31:0] INVULN_LOAD    = 32'(INVULN_CYCLES);
  localparam logic [7:0]  PLAYER_HP_INIT = 8'(PLAYER_HP);
  localparam logic [7:0]  ENEMY_HP_INIT  = 8'(ENEMY_HP);
  localparam logic [7:0]  HIT_DMG        = 8'(HIT_DAMAGE);
  localparam logic [7:0]  ATTACK_DMG     = 8'(ATTACK_DAMAGE);

  state_t      state_r;
  logic [3:0]  turn_r;
  logic [7:0]  player_hp_r;
  logic [7:0]  enemy_hp_r;
  logic        game_over_r;
  logic        hit_flash_r;
  logic [31:0] phase_cnt_r;
  logic [31:0] invuln_r;

  logic        hit_s;
  logic        enemy_exit_s;
  logic [7:0]  hp_after_hit_s;
  logic [7:0]  enemy_hp_attacked_s;

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    if (a > b) begin
      sat_sub = a - b;
    end else begin
      sat_sub = 8'd0;
    end
  endfunction

  // Same-cycle hit resolution and enemy-phase exit condition
  always_comb begin
    hit_s               = (state_r == ST_ENEMY) && bus.damage_in && (invuln_r == 32'd0);
    enemy_exit_s        = bus.finished_in || (phase_cnt_r == ENEMY_LAST);
    enemy_hp_attacked_s = sat_sub(enemy_hp_r, ATTACK_DMG);
    if (hit_s) begin
      hp_after_hit_s = sat_sub(player_hp_r, HIT_DMG);
    end else begin
      hp_after_hit_s = player_hp_r;
    end
  end

  // Phase sequencer with all outputs held in registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      turn_r      <= 4'd0;
      player_hp_r <= PLAYER_HP_INIT;
      enemy_hp_r  <= ENEMY_HP_INIT;
      game_over_r <= 1'b0;
      hit_flash_r <= 1'b0;
      phase_cnt_r <= 32'd0;
      invuln_r    <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_WIN, ST_LOSE: begin
          if (bus.start_in) begin
            state_r     <= ST_MENU;
            turn_r      <= 4'd0;
            player_hp_r <= PLAYER_HP_INIT;
            enemy_hp_r  <= ENEMY_HP_INIT;
            game_over_r <= 1'b0;
            hit_flash_r <= 1'b0;
            phase_cnt_r <= 32'd0;
            invuln_r    <= 32'd0;
          end
        end
        ST_MENU: begin
          if (bus.confirm_in) begin
            state_r     <= ST_ATTACK;
            enemy_hp_r  <= enemy_hp_attacked_s;
            phase_cnt_r <= 32'd0;
          end
        end
        ST_ATTACK: begin
          if (phase_cnt_r == ATTACK_LAST) begin
            phase_cnt_r <= 32'd0;
            invuln_r    <= 32'd0;
            if (enemy_hp_r == 8'd0) begin
              state_r     <= ST_WIN;
              game_over_r <= 1'b1;
            end else begin
              state_r <= ST_ENEMY;
            end
          end else begin
            phase_cnt_r <= phase_cnt_r + 32'd1;
          end
        end
        ST_ENEMY: begin
          player_hp_r <= hp_after_hit_s;
          if (enemy_exit_s) begin
            phase_cnt_r <= 32'd0;
            invuln_r    <= 32'd0;
            hit_flash_r <= 1'b0;
            if (hp_after_hit_s == 8'd0) begin
              state_r     <= ST_LOSE;
              game_over_r <= 1'b1;
            end else begin
              state_r <= ST_MENU;
              turn_r  <= turn_r + 4'd1;
            end
          end else begin
            phase_cnt_r <= phase_cnt_r + 32'd1;
            // Flash tracks the window: it drops together with the last count
            if (hit_s) begin
              invuln_r    <= INVULN_LOAD;
              hit_flash_r <= 1'b1;
            end else if (invuln_r != 32'd0) begin
              invuln_r    <= invuln_r - 32'd1;
              hit_flash_r <= (invuln_r > 32'd1);
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          game_over_r <= 1'b0;
          hit_flash_r <= 1'b0;
          phase_cnt_r <= 32'd0;
          invuln_r    <= 32'd0;
        end
      endcase
    end
  end

  assign bus.state_out     = state_r;
  assign bus.turn_out      = turn_r;
  assign bus.player_hp_out = player_hp_r;
  assign bus.enemy_hp_out  = enemy_hp_r;
  assign bus.game_over_out = game_over_r;
  assign bus.hit_flash_out = hit_flash_r;

endmodule

// File: doc/battle_controller.md
Name: battle_controller

Overview:
- Turn sequencer for the battle screen; drives the enemy phase block through `state_out`/`turn_out` and consumes its `busy_in`/`finished_in`/`damage_in` handshake.
- Owns player and enemy HP, the player menu/attack phases, the hit-invulnerability window, an enemy-phase watchdog, and win/lose detection.
- Sits between the top-level input debouncers and the enemy, HUD and render blocks.

Parameters:
- PLAYER_HP, 20, player starting HP (max 255).
- ENEMY_HP, 30, enemy starting HP (max 255).
- HIT_DAMAGE, 4, player HP removed per accepted hit.
- ATTACK_DAMAGE, 5, enemy HP removed per player attack.
- ATTACK_CYCLES, 32500000, duration of the PLAYER_ATTACK phase in clk cycles.
- INVULN_CYCLES, 6500000, cycles after an accepted hit during which `damage_in` is ignored.
- ENEMY_TIMEOUT, 650000000, watchdog limit in cycles for ENEMY_PHASE.

Ports:
- clk  in  1  pixel/system clock
- rst  in  1  synchronous, active-high reset
- start_in  in  1  one-cycle pulse, start/restart game
- confirm_in  in  1  one-cycle pulse, confirm attack in menu
- busy_in  in  1  enemy busy level
- finished_in  in  1  enemy one-cycle finish pulse
- damage_in  in  1  enemy hit indication (may be high on consecutive or alternating cycles)
- state_out  out  4  phase code: IDLE=0000, MENU=0001, ATTACK=0010, WIN=0100, LOSE=0101, ENEMY=1000
- turn_out  out  4  enemy pattern index
- player_hp_out  out  8  current player HP
- enemy_hp_out  out  8  current enemy HP
- game_over_out  out  1  high in WIN or LOSE
- hit_flash_out  out  1  high while the invulnerability window is active (HUD flash)

Behaviour:
- Reset (rst=1, sync): state_out=IDLE, turn_out=0, player_hp_out=PLAYER_HP, enemy_hp_out=ENEMY_HP, game_over_out=0, hit_flash_out=0, all counters 0. Reset mid-phase aborts immediately. The enemy sees state_out leave 1000; when re-entered later, this is a new rising edge.
- All outputs are registered and change one cycle after the causing input.
- IDLE: on start_in, go to MENU and reload both HP values and turn_out=0.
- MENU: on confirm_in, go to ATTACK. In the same transition, enemy_hp = max(enemy_hp − ATTACK_DAMAGE, 0) (saturating, no wrap). start_in is ignored in MENU.
- ATTACK: phase counter runs 0..ATTACK_CYCLES−1.
  - If enemy_hp==0 at the end of the count, go to WIN.
  - Otherwise go to ENEMY, and clear the phase counter and invuln counter.
- ENEMY: state_out=1000 is held for the whole phase; the enemy keys on the edge into this code.
  - damage_in=1 with the invuln counter at 0 is an accepted hit: player_hp = max(player_hp − HIT_DAMAGE, 0); invuln counter loaded with INVULN_CYCLES; hit_flash_out=1 until it counts to 0.
  - damage_in is ignored while invuln≠0.
  - On finished_in: if player_hp (after any same-cycle hit is applied) ==0, go to LOSE. Otherwise go to MENU with turn_out+1 (4-bit wrap, 15→0).
  - Watchdog: the counter increments each ENEMY cycle. On reaching ENEMY_TIMEOUT−1 without finished_in, take the same exit as finished_in.
  - finished_in and the timeout on the same cycle cause a single transition and a single increment.
  - player_hp reaching 0 mid-phase does not exit early; it waits for finished_in or the timeout.
- damage_in, finished_in and busy_in are ignored outside ENEMY. busy_in is informational only; no transition depends on it.
- WIN/LOSE: game_over_out=1; hit_flash_out forced 0. On start_in, go to MENU with both HP reloaded and turn_out=0.
- Counters: 32-bit; all are cleared on every state change.

Test Plan:
- Reset then start_in → state_out 0000→0001 one cycle later; player_hp_out=20, enemy_hp_out=30, turn_out=0.
- confirm_in in MENU → state 0010, enemy_hp_out=25. After 32500000 cycles → state 1000. A finished_in pulse → state 0001, turn_out=1.
- In ENEMY, damage_in high for 10 consecutive cycles → exactly one hit: player_hp_out 20→16, hit_flash_out=1 for 6500000 cycles. A second damage_in after the window → 12.
- player_hp=4, damage_in and finished_in on the same cycle → player_hp_out=0, state 0101, game_over_out=1. A later start_in → MENU, HP 20/30, turn 0.
- Six attacks with ENEMY_HP=30 → after the sixth ATTACK phase the state is 0100, enemy_hp_out=0 (never wraps). A seventh confirm is not possible (WIN ignores confirm_in).
- ENEMY with no finished_in → exit to MENU after exactly ENEMY_TIMEOUT cycles, turn_out incremented. With turn_out=15, an exit gives turn_out=0. Asserting rst mid-ENEMY → IDLE next cycle.
